// File: rtl/matrix_mac_pkg.sv
// ---------------------------------------------------------------------------
// matrix_mac_pkg
// Shared definitions for the matrix MAC datapath and its operand feeder.
//   DATA_WIDTH / DIM : default element width and square matrix dimension
//   IDX_W            : width of a row/column/term index for the default DIM
//   PTR_W            : width of an element address inside one operand bank
//   feeder_state_t   : operand feeder sequencing states
// ---------------------------------------------------------------------------
package matrix_mac_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DIM        = 4;
    localparam int IDX_W      = $clog2(DIM);
    localparam int PTR_W      = $clog2(DIM * DIM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/matrix_operand_feeder_if.sv
// ---------------------------------------------------------------------------
// matrix_operand_feeder_if
// Bundles the load port, the control pins and the MAC-facing pair stream of
// matrix_operand_feeder.
//   master : the side that loads operands, starts and stalls the feeder
//            (drives load_valid/load_sel/load_data/start/stall)
//   slave  : the feeder itself (drives load_ready, busy, done, mac_*,
//            matrix_1/matrix_2, row_idx/col_idx)
// The optional abort pin (MATRIX_FEEDER_ABORT_EN) is a plain port on the
// feeder, not part of this bundle.
// ---------------------------------------------------------------------------
interface matrix_operand_feeder_if #(
    parameter int DATA_WIDTH = matrix_mac_pkg::DATA_WIDTH,
    parameter int DIM        = matrix_mac_pkg::DIM
);

    localparam int IDX_BITS = $clog2(DIM);

    logic                  load_valid;
    logic                  load_ready;
    logic                  load_sel;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  start;
    logic                  stall;
    logic                  busy;
    logic                  done;
    logic                  mac_enable;
    logic                  mac_clear;
    logic                  mac_last;
    logic [DATA_WIDTH-1:0] matrix_1;
    logic [DATA_WIDTH-1:0] matrix_2;
    logic [IDX_BITS-1:0]   row_idx;
    logic [IDX_BITS-1:0]   col_idx;

    modport master (
        output load_valid, load_sel, load_data, start, stall,
        input  load_ready, busy, done, mac_enable, mac_clear, mac_last,
               matrix_1, matrix_2, row_idx, col_idx
    );

    modport slave (
        input  load_valid, load_sel, load_data, start, stall,
        output load_ready, busy, done, mac_enable, mac_clear, mac_last,
               matrix_1, matrix_2, row_idx, col_idx
    );

endinterface

// File: rtl/matrix_operand_bank.sv
// ---------------------------------------------------------------------------
// matrix_operand_bank
// DIM*DIM x DATA_WIDTH register file holding one operand matrix in
// row-major order. One synchronous write port, one combinational read port
// so the feeder can address and register an element in the same cycle.
// Contents are not reset.
//   clock : rising-edge clock
//   we    : write enable
//   waddr : write element address
//   wdata : write element value
//   raddr : read element address
//   rdata : element at raddr
// ---------------------------------------------------------------------------
module matrix_operand_bank #(
    parameter int DATA_WIDTH = matrix_mac_pkg::DATA_WIDTH,
    parameter int DIM        = matrix_mac_pkg::DIM
) (
    input  logic                          clock,
    input  logic                          we,
    input  logic [$clog2(DIM*DIM)-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [$clog2(DIM*DIM)-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]         rdata
);

    logic [DATA_WIDTH-1:0] mem_reg [DIM*DIM];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/matrix_operand_feeder.sv
// ---------------------------------------------------------------------------
// matrix_operand_feeder
// Buffers operand matrices A and B (loaded element-serially, row-major) and,
// on start, streams A[i][k] / B[k][j] pairs to the MAC with k innermost,
// then j, then i, flagging the first (mac_clear) and last (mac_last) term of
// every dot product. All outputs are registered.
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   abort  : (only with MATRIX_FEEDER_ABORT_EN) drop the current stream and
//            return to IDLE keeping both loaded matrices
//   bus    : matrix_operand_feeder_if.slave (load port, start/stall,
//            busy/done, mac_* strobes, matrix_1/matrix_2, row_idx/col_idx)
// Build option: define MATRIX_FEEDER_ABORT_EN to add the abort port.
// ---------------------------------------------------------------------------
module matrix_operand_feeder #(
    parameter int DATA_WIDTH = matrix_mac_pkg::DATA_WIDTH,
    parameter int DIM        = matrix_mac_pkg::DIM
) (
    input  logic                    clock,
    input  logic                    reset,
`ifdef MATRIX_FEEDER_ABORT_EN
    input  logic                    abort,
`endif
    matrix_operand_feeder_if.slave  bus
);

    import matrix_mac_pkg::*;

    localparam int CNT_W  = $clog2(DIM);
    localparam int ADDR_W = $clog2(DIM * DIM);
    localparam logic [CNT_W-1:0]  IDX_LAST = CNT_W'(DIM - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DIM * DIM - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(DIM);

    feeder_state_t         state_reg, state_next;
    logic [ADDR_W-1:0]     a_ptr_reg, a_ptr_next, b_ptr_reg, b_ptr_next;
    logic                  a_full_reg, a_full_next, b_full_reg, b_full_next;
    logic [CNT_W-1:0]      i_reg, i_next, j_reg, j_next, k_reg, k_next;
    logic                  drain_reg, drain_next;
    logic                  load_ready_reg, load_ready_next;
    logic                  busy_reg, busy_next, done_reg, done_next;
    logic                  mac_enable_reg, mac_enable_next;
    logic                  mac_clear_reg, mac_clear_next;
    logic                  mac_last_reg, mac_last_next;
    logic [DATA_WIDTH-1:0] matrix_1_reg, matrix_1_next;
    logic [DATA_WIDTH-1:0] matrix_2_reg, matrix_2_next;
    logic [CNT_W-1:0]      row_idx_reg, row_idx_next, col_idx_reg, col_idx_next;

    logic                  abort_req;
    logic                  load_fire, a_we, b_we;
    logic                  present, issue;
    logic [ADDR_W-1:0]     a_raddr, b_raddr;
    logic [DATA_WIDTH-1:0] a_rdata, b_rdata;

`ifdef MATRIX_FEEDER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // load_ready is only ever high in IDLE, so it doubles as the load gate.
    assign load_fire = bus.load_valid & load_ready_reg;
    assign a_we      = load_fire & ~bus.load_sel;
    assign b_we      = load_fire &  bus.load_sel;

    // The i/j/k counters always name the next pair to present.
    assign a_raddr = ADDR_W'(i_reg) * ROW_STEP + ADDR_W'(k_reg);
    assign b_raddr = ADDR_W'(k_reg) * ROW_STEP + ADDR_W'(j_reg);

    matrix_operand_bank #(.DATA_WIDTH(DATA_WIDTH), .DIM(DIM)) u_bank_a (
        .clock (clock),
        .we    (a_we),
        .waddr (a_ptr_reg),
        .wdata (bus.load_data),
        .raddr (a_raddr),
        .rdata (a_rdata)
    );

    matrix_operand_bank #(.DATA_WIDTH(DATA_WIDTH), .DIM(DIM)) u_bank_b (
        .clock (clock),
        .we    (b_we),
        .waddr (b_ptr_reg),
        .wdata (bus.load_data),
        .raddr (b_raddr),
        .rdata (b_rdata)
    );

    always_comb begin
        state_next  = state_reg;
        a_ptr_next  = a_ptr_reg;
        b_ptr_next  = b_ptr_reg;
        a_full_next = a_full_reg;
        b_full_next = b_full_reg;
        i_next      = i_reg;
        j_next      = j_reg;
        k_next      = k_reg;
        present     = 1'b0;   // output registers take the pair at i/j/k
        issue       = 1'b0;   // ... and it counts as a real MAC term

        case (state_reg)
            IDLE: begin
                if (a_we) begin
                    a_ptr_next = (a_ptr_reg == PTR_LAST) ? '0 : a_ptr_reg + 1'b1;
                    if (a_ptr_reg == PTR_LAST) a_full_next = 1'b1;
                end
                if (b_we) begin
                    b_ptr_next = (b_ptr_reg == PTR_LAST) ? '0 : b_ptr_reg + 1'b1;
                    if (b_ptr_reg == PTR_LAST) b_full_next = 1'b1;
                end
                // Flags sampled before any same-cycle write lands.
                if (bus.start && a_full_reg && b_full_reg) begin
                    state_next = STREAM;
                    present    = 1'b1;
                    issue      = 1'b1;
                end
            end
            STREAM: begin
                if (abort_req) begin
                    state_next = IDLE;
                end else if (drain_reg) begin
                    state_next = DONE;
                end else begin
                    // A stalled cycle still loads the pending pair so it sits
                    // on the outputs with mac_enable low until released.
                    present = 1'b1;
                    issue   = ~bus.stall;
                end
            end
            DONE: begin
                a_full_next = 1'b0;
                b_full_next = 1'b0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (issue) begin
            if (k_reg == IDX_LAST) begin
                k_next = '0;
                if (j_reg == IDX_LAST) begin
                    j_next = '0;
                    i_next = (i_reg == IDX_LAST) ? '0 : i_reg + 1'b1;
                end else begin
                    j_next = j_reg + 1'b1;
                end
            end else begin
                k_next = k_reg + 1'b1;
            end
        end

        // Every new stream starts from (0,0,0), including after an abort.
        if (state_next != STREAM) begin
            i_next = '0;
            j_next = '0;
            k_next = '0;
        end

        drain_next = issue && (state_reg == STREAM) &&
                     (i_reg == IDX_LAST) && (j_reg == IDX_LAST) && (k_reg == IDX_LAST);

        load_ready_next = (state_next == IDLE);
        busy_next       = (state_next == STREAM);
        done_next       = (state_next == DONE);
        mac_enable_next = issue;
        mac_clear_next  = present && (k_reg == '0);
        mac_last_next   = present && (k_reg == IDX_LAST);

        matrix_1_next = matrix_1_reg;
        matrix_2_next = matrix_2_reg;
        row_idx_next  = row_idx_reg;
        col_idx_next  = col_idx_reg;
        if (present) begin
            matrix_1_next = a_rdata;
            matrix_2_next = b_rdata;
            row_idx_next  = i_reg;
            col_idx_next  = j_reg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            a_ptr_reg      <= '0;
            b_ptr_reg      <= '0;
            a_full_reg     <= 1'b0;
            b_full_reg     <= 1'b0;
            i_reg          <= '0;
            j_reg          <= '0;
            k_reg          <= '0;
            drain_reg      <= 1'b0;
            load_ready_reg <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            mac_enable_reg <= 1'b0;
            mac_clear_reg  <= 1'b0;
            mac_last_reg   <= 1'b0;
            matrix_1_reg   <= '0;
            matrix_2_reg   <= '0;
            row_idx_reg    <= '0;
            col_idx_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            a_ptr_reg      <= a_ptr_next;
            b_ptr_reg      <= b_ptr_next;
            a_full_reg     <= a_full_next;
            b_full_reg     <= b_full_next;
            i_reg          <= i_next;
            j_reg          <= j_next;
            k_reg          <= k_next;
            drain_reg      <= drain_next;
            load_ready_reg <= load_ready_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            mac_enable_reg <= mac_enable_next;
            mac_clear_reg  <= mac_clear_next;
            mac_last_reg   <= mac_last_next;
            matrix_1_reg   <= matrix_1_next;
            matrix_2_reg   <= matrix_2_next;
            row_idx_reg    <= row_idx_next;
            col_idx_reg    <= col_idx_next;
        end
    end

    assign bus.load_ready = load_ready_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.mac_enable = mac_enable_reg;
    assign bus.mac_clear  = mac_clear_reg;
    assign bus.mac_last   = mac_last_reg;
    assign bus.matrix_1   = matrix_1_reg;
    assign bus.matrix_2   = matrix_2_reg;
    assign bus.row_idx    = row_idx_reg;
    assign bus.col_idx    = col_idx_reg;

endmodule

// File: doc/matrix_operand_feeder.md
Name: matrix_operand_feeder

Overview:
Upstream stage of matrix_mac_unit. Buffers two DIM x DIM operand matrices, A and B, loaded element-serially over a valid/ready port. On start, it streams element pairs to the MAC in dot-product order. Each pair is A[i][k] on matrix_1 and B[k][j] on matrix_2, with per-element enable, first-term clear and last-term strobes, so the MAC produces C = A x B one element at a time.

Parameters:
DATA_WIDTH, 8, element width; matches matrix_mac_unit.
DIM, 4, matrix dimension (square), >= 2.

Ports:
clock       input   1           sole clock, rising edge
reset       input   1           asynchronous, active-low reset
load_valid  input   1           load element present
load_ready  output  1           feeder accepts load element
load_sel    input   1           0 = element for A, 1 = element for B
load_data   input   DATA_WIDTH  element value, row-major order
start       input   1           begin multiply (single-cycle pulse)
stall       input   1           downstream backpressure
busy        output  1           streaming in progress
done        output  1           one-cycle pulse after final pair
mac_enable  output  1           matrix_1/matrix_2 hold a valid pair
mac_clear   output  1           pair is first term (k==0); MAC restarts accumulation
mac_last    output  1           pair is last term (k==DIM-1)
matrix_1    output  DATA_WIDTH  A[i][k]
matrix_2    output  DATA_WIDTH  B[k][j]
row_idx     output  IDX_W       i of the result element being formed
col_idx     output  IDX_W       j of the result element being formed

Behaviour:
- IDX_W = $clog2(DIM). All outputs are registered.
- Reset (asynchronous, reset==0):
  - state IDLE; all counters and pointers 0; a_full and b_full cleared.
  - busy, done, mac_* = 0; matrix_1, matrix_2, row_idx, col_idx = 0.
  - Bank contents are don't-care.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - load_ready=1. A handshake (load_valid & load_ready) writes load_data to the bank chosen by load_sel at that bank's write pointer, then increments the pointer.
  - When a pointer reaches DIM*DIM-1 and is written, the pointer wraps to 0 and that bank's full flag sets. Further writes overwrite from element 0; the full flag stays set.
  - start is accepted only when a_full & b_full, evaluated on pre-write flags if a load occurs in the same cycle; otherwise start is ignored.
  - Accepted start moves to STREAM with i=j=k=0.
- STREAM:
  - load_ready=0; busy=1.
  - The first pair appears on outputs the cycle after start is accepted.
  - Each non-stalled cycle presents one pair with mac_enable=1, mac_clear=(k==0), mac_last=(k==DIM-1).
  - Iteration order: k innermost, then j, then i.
  - Unstalled stream length is DIM^3 cycles.
- Stall:
  - While stall=1, matrix_1, matrix_2, row_idx, col_idx, mac_clear and mac_last hold; mac_enable=0; counters do not advance.
  - The held pair is re-presented with mac_enable=1 on the first cycle stall=0.
  - Stall is ignored outside STREAM.
- After the pair (i,j,k) = (DIM-1, DIM-1, DIM-1) is presented unstalled, move to DONE.
- DONE (one cycle): done=1, busy=0, mac_* = 0; clear a_full and b_full; return to IDLE. A start arriving in DONE is ignored.
- Reset asserted mid-stream aborts immediately. There is no done pulse and both matrices must be reloaded.

Optional Feature:
MATRIX_FEEDER_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in STREAM forces IDLE on the next edge.
  - mac_enable=0 that cycle onward; no done pulse.
  - a_full and b_full are retained, so start may be reissued without reloading.
  - abort outside STREAM is ignored; abort has priority over stall.
- Undefined: no abort port; STREAM exits only via completion or reset.

Decomposition:
- Package matrix_mac_pkg:
  - DATA_WIDTH and DIM defaults
  - IDX_W and PTR_W = $clog2(DIM*DIM) localparams
  - typedef enum feeder_state_t {IDLE, STREAM, DONE}
- Sub-module matrix_operand_bank: DIM*DIM x DATA_WIDTH register file with one write port (we, waddr, wdata) and one combinational read port (raddr, rdata). Instantiated twice, for A and B.
- Feeder contains the FSM, load pointers, i/j/k counters and output registers.

Test Plan:
1. DIM=2, load A=[1,2;3,4], B=[5,6;7,8], start, no stall -> cycles 1..8 present pairs (1,5)(2,7)(1,6)(2,8)(3,5)(4,7)(3,6)(4,8). mac_clear on pairs 1,3,5,7; mac_last on pairs 2,4,6,8; done at cycle 9; load_ready=1 at cycle 10.
2. Load A only, pulse start -> ignored: busy stays 0, mac_enable stays 0. Then load B and pulse start -> stream runs as in scenario 1.
3. Scenario 1 with stall=1 during cycles 3-5 -> pair (1,6) held with mac_enable=0 for those 3 cycles. Remaining sequence unchanged; done at cycle 12.
4. DIM=2, load 5 elements to A (5th value 9), then 4 to B, start -> first pair (9,B[0][0]); A[0][1..1][1] keep values 2..4.
5. Assert reset at the 4th stream cycle -> all outputs 0 immediately. Start after release is ignored until both matrices are reloaded.
6. With MATRIX_FEEDER_ABORT_EN, abort at the 3rd stream cycle -> IDLE next cycle, no done. Start immediately accepted, and the full sequence from scenario 1 replays.
